// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus responder.
// Contents: host bus widths, the default backing-store address width,
// the responder FSM state encoding and a helper that says whether a
// state owns the data transceiver direction.
package sram_bus_pkg;
  localparam int SRAM_ADDR_W = 15;
  localparam int SRAM_DATA_W = 8;
  localparam int MEM_AW_DEF  = 13;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_FETCH = 3'd2,
    ST_READ_DRIVE = 3'd3,
    ST_TURN       = 3'd4
  } state_e;

  // Transceiver points FPGA->host from fetch until the turnaround cycle ends.
  function automatic logic drives_tx(input state_e s);
    return (s == ST_READ_FETCH) || (s == ST_READ_DRIVE) || (s == ST_TURN);
  endfunction
endpackage

// File: rtl/sram_resp_sync.sv
// N-stage synchroniser with optional rise/fall detect on the synced value.
// Ports:
//   clk, n_reset   clock, async active-low reset
//   i_d [W]        asynchronous input
//   o_q [W]        synchronised value (STAGES flops of latency)
//   o_rise/o_fall  one-cycle pulses on synced 0->1 / 1->0 (0 when EDGE_EN=0)
module sram_resp_sync #(
  parameter int           W       = 1,
  parameter int           STAGES  = 2,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter bit           EDGE_EN = 1'b0
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);
  logic [STAGES-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_pipe <= {STAGES{RST_VAL}};
    else          r_pipe <= {r_pipe[STAGES-2:0], i_d};
  end

  assign o_q = r_pipe[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [W-1:0] r_prev;
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_prev <= RST_VAL;
        else          r_prev <= o_q;
      end
      assign o_rise = o_q & ~r_prev;
      assign o_fall = ~o_q & r_prev;
    end else begin : g_no_edge
      assign o_rise = '0;
      assign o_fall = '0;
    end
  endgenerate
endmodule

// File: rtl/sram_bus_responder.sv
// Emulates an async byte-wide SRAM on the board bus, backed by on-chip BRAM.
// Ports:
//   clk, n_reset                 system clock, async active-low reset
//   addr[15], data_in[8]         host address / write data (receive only)
//   sram_n_ce/n_oe/n_write       host strobes, active low
//   data_out[8], data_oe         read data and pad enable toward host
//   trans_tx_data                data transceiver direction (1 = to host)
//   trans_tx_addr                addr transceiver direction, always receive
//   trans_n_oe                   transceiver enable, low once out of reset
//   LED[8]                       status
// Build option SRAM_RESP_STATS_EN: saturating write/read counters, LED shows
// the write count; otherwise LED shows the low byte of the last write address.
module sram_bus_responder
  import sram_bus_pkg::*;
#(
  parameter int MEM_AW      = MEM_AW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [SRAM_DATA_W-1:0] data_in,
  output logic [SRAM_DATA_W-1:0] data_out,
  output logic                   data_oe,
  input  logic                   sram_n_ce,
  input  logic                   sram_n_oe,
  input  logic                   sram_n_write,
  output logic                   trans_tx_data,
  output logic                   trans_tx_addr,
  output logic                   trans_n_oe,
  output logic [7:0]             LED
);
  localparam int BUS_W = SRAM_ADDR_W + SRAM_DATA_W;

  logic [2:0]             w_ctrl, w_ctrl_rise, w_unused_ctrl_fall;
  logic [BUS_W-1:0]       w_bus, w_unused_bus_rise, w_unused_bus_fall;
  logic                   w_s_ce, w_s_oe, w_s_we, w_ce_rise, w_we_rise;
  logic [SRAM_ADDR_W-1:0] w_s_addr;
  logic [SRAM_DATA_W-1:0] w_s_data;
  logic [MEM_AW-1:0]      w_mem_addr;
  logic                   w_unused_addr;

  // Strobes idle high so reset leaves them inactive and produces no edge.
  sram_resp_sync #(.W(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b111), .EDGE_EN(1'b1)) u_sync_ctrl (
    .clk(clk), .n_reset(n_reset),
    .i_d({sram_n_ce, sram_n_oe, sram_n_write}),
    .o_q(w_ctrl), .o_rise(w_ctrl_rise), .o_fall(w_unused_ctrl_fall)
  );

  sram_resp_sync #(.W(BUS_W), .STAGES(SYNC_STAGES), .RST_VAL('0), .EDGE_EN(1'b0)) u_sync_bus (
    .clk(clk), .n_reset(n_reset),
    .i_d({addr, data_in}),
    .o_q(w_bus), .o_rise(w_unused_bus_rise), .o_fall(w_unused_bus_fall)
  );

  assign {w_s_ce, w_s_oe, w_s_we} = w_ctrl;
  assign w_ce_rise  = w_ctrl_rise[2];
  assign w_we_rise  = w_ctrl_rise[0];
  assign {w_s_addr, w_s_data} = w_bus;
  // Upper host address bits alias onto the smaller backing store.
  assign w_mem_addr    = w_s_addr[MEM_AW-1:0];
  assign w_unused_addr = ^w_s_addr;

  state_e                  r_state, w_next;
  logic                    w_commit, w_capture;
  logic                    r_data_oe, r_tx_data, r_trans_n_oe;
  logic [SRAM_DATA_W-1:0]  r_data_out, r_rdata, r_wdata;
  logic [MEM_AW-1:0]       r_waddr;
  logic [SRAM_DATA_W-1:0]  r_mem [0:(1<<MEM_AW)-1];

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Write has priority: a simultaneous n_oe never turns the bus around.
        if (!w_s_ce && !w_s_we) begin
          w_next    = ST_WRITE;
          w_capture = 1'b1;
        end else if (!w_s_ce && !w_s_oe) begin
          w_next = ST_READ_FETCH;
        end
      end
      ST_WRITE: begin
        // End of strobe stores the last value seen while it was still low.
        if (w_we_rise || w_ce_rise) begin
          w_commit = 1'b1;
          w_next   = ST_IDLE;
        end else begin
          w_capture = !w_s_ce && !w_s_we;
        end
      end
      ST_READ_FETCH: w_next = ST_READ_DRIVE;
      ST_READ_DRIVE: if (w_s_oe || w_s_ce || !w_s_we) w_next = ST_TURN;
      ST_TURN:       w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the pad enable drops in
  // TURN while the transceiver still points out, and flips back one later.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= ST_IDLE;
      r_data_oe    <= 1'b0;
      r_tx_data    <= 1'b0;
      r_trans_n_oe <= 1'b1;
      r_data_out   <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_next;
      r_data_oe    <= (w_next == ST_READ_DRIVE);
      r_tx_data    <= drives_tx(w_next);
      r_trans_n_oe <= 1'b0;
      // BRAM output follows s_addr every cycle, so an address change while
      // driving reaches the pad two cycles later.
      if (w_next == ST_READ_DRIVE) r_data_out <= r_rdata;
      if (w_capture) begin
        r_waddr <= w_mem_addr;
        r_wdata <= w_s_data;
      end
    end
  end

  // Backing store has no reset: contents survive n_reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_waddr] <= r_wdata;
    r_rdata <= r_mem[w_mem_addr];
  end

  assign data_out      = r_data_out;
  assign data_oe       = r_data_oe;
  assign trans_tx_data = r_tx_data;
  assign trans_tx_addr = 1'b0;
  assign trans_n_oe    = r_trans_n_oe;

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] r_wr_cnt, r_rd_cnt;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_commit && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (r_state == ST_IDLE && w_next == ST_READ_FETCH && r_rd_cnt != 16'hFFFF)
        r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end
  assign LED = r_wr_cnt[7:0];
`else
  logic [7:0] r_led;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)      r_led <= '0;
    else if (w_commit) r_led <= r_waddr[7:0];
  end
  assign LED = r_led;
`endif
endmodule
